// File: rtl/tmp_spi_ctrl.sv
// SPI temperature-sensor read controller: one 16-bit frame per trigger, data byte = frame[14:7].
// Optional periodic self-trigger is built only when TMP_CTRL_PERIODIC_EN is defined.
module tmp_spi_ctrl #(
  parameter int CLK_DIV = 4,
  parameter int PERIOD  = 100000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       period_en,
  output logic       busy,
  output logic       done,
  output logic       data_wr,
  output logic [7:0] data_out,
  output logic       spi_cs_n,
  output logic       spi_sclk,
  input  logic       spi_miso
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    SETUP = 3'd1,
    SHIFT = 3'd2,
    HOLD  = 3'd3,
    DONE  = 3'd4
  } state_t;

  localparam logic [7:0] DIV_LAST = 8'(CLK_DIV - 1);

  state_t      state_r, state_s;
  logic [7:0]  div_r, div_s;
  logic [4:0]  half_r, half_s;
  logic [15:0] shreg_r, shreg_s;
  logic [1:0]  sync_r;
  logic        cs_n_r, cs_n_s;
  logic        sclk_r, sclk_s;
  logic        done_r, done_s;
  logic        busy_r;
  logic [7:0]  data_r, data_s;
  logic        trig_s;

`ifdef TMP_CTRL_PERIODIC_EN
  localparam int PW = (PERIOD > 1) ? $clog2(PERIOD) : 1;
  logic [PW-1:0] per_cnt_r;
  logic          pend_r;

  // Period counter; a pending trigger survives until the FSM is back in IDLE.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      per_cnt_r <= '0;
      pend_r    <= 1'b0;
    end else if (!period_en) begin
      per_cnt_r <= '0;
      pend_r    <= 1'b0;
    end else if (per_cnt_r == PW'(PERIOD - 1)) begin
      per_cnt_r <= '0;
      pend_r    <= 1'b1;
    end else begin
      per_cnt_r <= per_cnt_r + PW'(1);
      if (state_r == IDLE) begin
        pend_r <= 1'b0;
      end
    end
  end

  assign trig_s = start | pend_r;
`else
  // period_en is kept on the port but has no effect in this build.
  assign trig_s = start | (period_en & 1'b0);
`endif

  // Next-state, counters and next values of every registered output.
  always_comb begin
    state_s  = state_r;
    div_s    = div_r;
    half_s   = half_r;
    shreg_s  = shreg_r;
    cs_n_s   = 1'b1;
    sclk_s   = 1'b0;
    done_s   = 1'b0;
    data_s   = data_r;
    case (state_r)
      IDLE: begin
        if (trig_s) begin
          state_s = SETUP;
          div_s   = 8'd0;
          cs_n_s  = 1'b0;
        end else begin
          state_s = IDLE;
        end
      end
      SETUP: begin
        cs_n_s = 1'b0;
        if (div_r == DIV_LAST) begin
          state_s = SHIFT;
          div_s   = 8'd0;
          half_s  = 5'd0;
        end else begin
          div_s = div_r + 8'd1;
        end
      end
      SHIFT: begin
        cs_n_s = 1'b0;
        if (div_r == DIV_LAST) begin
          div_s = 8'd0;
          if (half_r == 5'd31) begin
            state_s = HOLD;
          end else begin
            // Even-to-odd half boundary is the SCLK rising edge: sample here.
            half_s = half_r + 5'd1;
            sclk_s = ~half_r[0];
            if (!half_r[0]) begin
              shreg_s = {shreg_r[14:0], sync_r[1]};
            end else begin
              shreg_s = shreg_r;
            end
          end
        end else begin
          div_s  = div_r + 8'd1;
          sclk_s = half_r[0];
        end
      end
      HOLD: begin
        cs_n_s = 1'b0;
        if (div_r == DIV_LAST) begin
          state_s = DONE;
          cs_n_s  = 1'b1;
          done_s  = 1'b1;
          data_s  = shreg_r[14:7];
        end else begin
          div_s = div_r + 8'd1;
        end
      end
      DONE: begin
        state_s = IDLE;
      end
      default: begin
        state_s = IDLE;
      end
    endcase
  end

  // State, counters, synchronizer and registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r <= IDLE;
      div_r   <= 8'd0;
      half_r  <= 5'd0;
      shreg_r <= 16'h0000;
      sync_r  <= 2'b00;
      cs_n_r  <= 1'b1;
      sclk_r  <= 1'b0;
      done_r  <= 1'b0;
      busy_r  <= 1'b0;
      data_r  <= 8'h00;
    end else begin
      state_r <= state_s;
      div_r   <= div_s;
      half_r  <= half_s;
      shreg_r <= shreg_s;
      sync_r  <= {sync_r[0], spi_miso};
      cs_n_r  <= cs_n_s;
      sclk_r  <= sclk_s;
      done_r  <= done_s;
      busy_r  <= (state_s != IDLE);
      data_r  <= data_s;
    end
  end

  assign busy     = busy_r;
  assign done     = done_r;
  assign data_wr  = done_r;
  assign data_out = data_r;
  assign spi_cs_n = cs_n_r;
  assign spi_sclk = sclk_r;

endmodule

// File: tb/tb_tmp_spi_ctrl.sv
// Self-checking bench for tmp_spi_ctrl: per-cycle timeline model plus directed literal checks.
module tb_tmp_spi_ctrl;
  localparam int D   = 4;
  localparam int P   = 500;
  localparam int LOW = 34 * D;

  logic clk = 1'b0;
  logic rst = 1'b1, start = 1'b0, period_en = 1'b0, spi_miso = 1'b0;
  logic busy, done, data_wr, spi_cs_n, spi_sclk;
  logic [7:0]  data_out;
  logic [15:0] frame = 16'h0000;

  int vecs = 0, errs = 0, cyc = 0;
  int rises = 0, dones = 0, wrs = 0, bad_sclk = 0;

  // model state: a read is a timeline relative to its trigger cycle t0
  bit          m_act = 1'b0;
  int          t0 = 0;
  logic [15:0] m_frame = 16'h0000;
  logic [7:0]  m_data = 8'h00;
  logic        prev_sclk_m = 1'b0;
`ifdef TMP_CTRL_PERIODIC_EN
  int pcnt = 0;
  bit pend = 1'b0;
`endif

  always #5 clk = ~clk;

  tmp_spi_ctrl #(.CLK_DIV(D), .PERIOD(P)) dut (
    .clk(clk), .rst(rst), .start(start), .period_en(period_en),
    .busy(busy), .done(done), .data_wr(data_wr), .data_out(data_out),
    .spi_cs_n(spi_cs_n), .spi_sclk(spi_sclk), .spi_miso(spi_miso)
  );

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    vecs++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Sensor: MSB first, next bit after each SCLK falling edge.
  int  s_idx = 15;
  logic s_prev = 1'b0;
  always @(negedge clk) begin
    if (spi_cs_n) begin
      s_idx = 15;
      spi_miso = frame[15];
    end else if (s_prev && !spi_sclk && s_idx > 0) begin
      s_idx = s_idx - 1;
      spi_miso = frame[s_idx];
    end
    s_prev = spi_sclk;
  end

  // Model and per-cycle compare.
  always @(negedge clk) begin : cmp
    int   rel;
    logic e_cs, e_sclk, e_busy, e_done;
    bit   was_idle, ptrig;
    cyc = cyc + 1;
    if (rst) begin
      m_act = 1'b0;
      m_data = 8'h00;
    end
    rel = cyc - t0;
    if (m_act && rel > LOW + 1) m_act = 1'b0;
    e_cs = 1'b1; e_sclk = 1'b0; e_busy = 1'b0; e_done = 1'b0;
    if (m_act) begin
      e_busy = 1'b1;
      e_cs   = (rel > LOW);
      e_done = (rel == LOW + 1);
      if (rel > D && rel <= 33 * D) e_sclk = (((rel - D - 1) / D) % 2 == 1);
      if (e_done) m_data = m_frame[14:7];
    end
    check("cs_n", 32'(spi_cs_n), 32'(e_cs));
    check("sclk", 32'(spi_sclk), 32'(e_sclk));
    check("busy", 32'(busy), 32'(e_busy));
    check("done", 32'(done), 32'(e_done));
    check("data_wr", 32'(data_wr), 32'(e_done));
    check("data_out", 32'(data_out), 32'(m_data));
    if (spi_sclk && !prev_sclk_m) rises++;
    prev_sclk_m = spi_sclk;
    if (done) dones++;
    if (data_wr) wrs++;
    if (spi_cs_n && spi_sclk) bad_sclk++;
    was_idle = !m_act;
    ptrig = 1'b0;
`ifdef TMP_CTRL_PERIODIC_EN
    ptrig = pend;
`endif
    if (!rst && was_idle && (start || ptrig)) begin
      m_act = 1'b1;
      t0 = cyc;
      m_frame = frame;
    end
`ifdef TMP_CTRL_PERIODIC_EN
    if (rst || !period_en) begin
      pcnt = 0;
      pend = 1'b0;
    end else if (pcnt == P - 1) begin
      pcnt = 0;
      pend = 1'b1;
    end else begin
      pcnt = pcnt + 1;
      if (was_idle) pend = 1'b0;
    end
`endif
  end

  task automatic pulse_start();
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
  endtask

  task automatic do_read(input logic [15:0] f, output int lat, output int low);
    frame = f;
    pulse_start();
    lat = 0;
    low = 0;
    for (int n = 1; n <= 400; n++) begin
      @(negedge clk);
      if (!spi_cs_n) low++;
      if (done) begin
        lat = n;
        break;
      end
    end
  endtask

  initial begin
    int lat, low, r0, d0, w0, lowc, busyc, nd;
    int dt[8];
    repeat (3) @(posedge clk);
    #1;
    check("rst_cs_n", 32'(spi_cs_n), 32'd1);
    check("rst_data", 32'(data_out), 32'h00);
    check("rst_busy", 32'(busy), 32'd0);
    rst = 1'b0;
    repeat (3) @(posedge clk);

    // nominal read, frame 0C80
    r0 = rises;
    do_read(16'h0C80, lat, low);
    check("lat_0c80", 32'(lat), 32'd137);
    check("cs_low_0c80", 32'(low), 32'd136);
    check("data_0c80", 32'(data_out), 32'h19);
    check("rises_0c80", 32'(rises - r0), 32'd16);

    // frame F380
    repeat (5) @(posedge clk);
    r0 = rises;
    do_read(16'hF380, lat, low);
    check("data_f380", 32'(data_out), 32'hE7);
    check("rises_f380", 32'(rises - r0), 32'd16);
    check("sclk_cs_high", 32'(bad_sclk), 32'd0);

    // second start during a read is ignored
    repeat (5) @(posedge clk);
    d0 = dones;
    frame = 16'h5A5A;
    pulse_start();
    repeat (48) @(posedge clk);
    pulse_start();
    repeat (300) @(negedge clk);
    check("one_done", 32'(dones - d0), 32'd1);
    check("data_5a5a", 32'(data_out), 32'(8'hB4));
    repeat (50) @(negedge clk);
    check("no_extra_read", 32'(dones - d0), 32'd1);
    check("idle_after", 32'(busy), 32'd0);
    do_read(16'h3F80, lat, low);
    check("lat_after_ignore", 32'(lat), 32'd137);

    // reset mid-read
    repeat (5) @(posedge clk);
    w0 = wrs;
    frame = 16'hFFFF;
    pulse_start();
    repeat (69) @(posedge clk);
    #1 rst = 1'b1;
    #1;
    check("abort_cs_n", 32'(spi_cs_n), 32'd1);
    check("abort_sclk", 32'(spi_sclk), 32'd0);
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_data", 32'(data_out), 32'h00);
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    repeat (200) @(negedge clk);
    check("abort_no_wr", 32'(wrs - w0), 32'd0);
    check("abort_idle", 32'(busy), 32'd0);

    // period_en held high without start
    frame = 16'h0C80;
    @(posedge clk); #1 period_en = 1'b1;
    lowc = 0; busyc = 0; nd = 0;
    for (int n = 1; n <= 2200; n++) begin
      @(negedge clk);
      if (!spi_cs_n) lowc++;
      if (busy) busyc++;
      if (done) begin
        if (nd < 8) dt[nd] = n;
        nd++;
      end
    end
    @(posedge clk); #1 period_en = 1'b0;
`ifdef TMP_CTRL_PERIODIC_EN
    check("periodic_dones", 32'(nd), 32'd4);
    for (int k = 1; k < 4 && k < nd; k++) check("periodic_space", 32'(dt[k] - dt[k-1]), 32'd500);
`else
    check("ignored_cs", 32'(lowc), 32'd0);
    check("ignored_busy", 32'(busyc), 32'd0);
    check("ignored_done", 32'(nd), 32'd0);
`endif

    // randomized traffic with occasional resets
    repeat (5) @(posedge clk);
    for (int i = 0; i < 3000; i++) begin
      @(posedge clk);
      #1;
      rst = ($urandom_range(0, 599) == 0);
      if (!busy) frame = 16'($urandom);
      start = !rst && ($urandom_range(0, 9) == 0);
      period_en = ($urandom_range(0, 1) == 1);
    end
    @(posedge clk); #1 start = 1'b0; rst = 1'b0; period_en = 1'b0;
    repeat (300) @(negedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end
endmodule

// File: doc/tmp_spi_ctrl.md
TMP_SPI_CTRL -- requirements
Module: tmp_spi_ctrl

Interface
REQ-001 SHALL have parameter CLK_DIV, default 4: clk cycles per SCLK half-period; legal range 3..255.
REQ-002 SHALL have parameter PERIOD, default 100000: clk cycles between automatic samples; used only when TMP_CTRL_PERIODIC_EN is defined.
REQ-003 SHALL have port clk  in  1  system clock; all logic on its rising edge.
REQ-004 SHALL have port rst  in  1  reset, asynchronous, active-high.
REQ-005 SHALL have port start  in  1  one-cycle request for one sensor read.
REQ-006 SHALL have port period_en  in  1  enables automatic periodic reads.
REQ-007 SHALL have port busy  out  1  high whenever the FSM is not in IDLE.
REQ-008 SHALL have port done  out  1  one-cycle pulse at the end of a read.
REQ-009 SHALL have port data_wr  out  1  write strobe to the data register; same cycle as done.
REQ-010 SHALL have port data_out  out  8  temperature byte; valid while data_wr is high and held afterwards.
REQ-011 SHALL have port spi_cs_n  out  1  sensor chip select, active-low.
REQ-012 SHALL have port spi_sclk  out  1  sensor serial clock; idles low.
REQ-013 SHALL have port spi_miso  in  1  sensor serial data, asynchronous to clk.

Function
REQ-014 SHALL implement the FSM states IDLE, SETUP, SHIFT, HOLD and DONE.
REQ-015 SHALL leave IDLE for SETUP on the cycle after a trigger (start, or an internal periodic trigger); spi_cs_n SHALL go low in that cycle.
REQ-016 SHALL stay in SETUP for CLK_DIV cycles with spi_sclk low.
REQ-017 SHALL, in SHIFT, generate 16 SCLK periods (low half, then high half, CLK_DIV cycles each), for 32*CLK_DIV cycles.
REQ-018 SHALL pass spi_miso through a 2-flop synchronizer and shift the synchronized bit into a 16-bit register, MSB first, in each cycle where spi_sclk goes from 0 to 1.
REQ-019 SHALL stay in HOLD for CLK_DIV cycles with spi_sclk low and spi_cs_n low, then enter DONE.
REQ-020 SHALL, in DONE (1 cycle): drive spi_cs_n high; set data_out to frame bits [14:7]; pulse done and data_wr; return to IDLE.
REQ-021 SHALL keep spi_cs_n low for exactly 34*CLK_DIV cycles; done SHALL occur 34*CLK_DIV+1 cycles after the trigger cycle.
REQ-022 SHALL ignore start while busy is high; requests are not queued.
REQ-023 SHALL hold data_out unchanged between DONE pulses.
REQ-024 SHALL, if start and a periodic trigger coincide, perform a single read.

Reset
REQ-025 SHALL, while rst is high, force: FSM to IDLE; spi_cs_n=1; spi_sclk=0; busy=0; done=0; data_wr=0; data_out=8'h00; shift register, synchronizer, divider and period counters to 0.
REQ-026 SHALL abort a read when rst is asserted mid-read, with no data_wr pulse; after rst is released, the block SHALL wait for a new trigger.

Configuration
REQ-027 SHALL, when TMP_CTRL_PERIODIC_EN is defined, count clk cycles while period_en=1; on reaching PERIOD-1 it SHALL raise a pending trigger and restart the count from 0.
REQ-028 SHALL, with TMP_CTRL_PERIODIC_EN defined, consume a pending trigger when the FSM is in IDLE; a trigger raised while busy SHALL wait until IDLE.
REQ-029 SHALL, with TMP_CTRL_PERIODIC_EN defined, clear the counter and any pending trigger when period_en=0.
REQ-030 SHALL, when TMP_CTRL_PERIODIC_EN is undefined, keep the period_en port but ignore it; no period counter SHALL be built, and only start triggers reads.

Verification
REQ-031 SHALL cover: CLK_DIV=4, sensor model sends 16'h0C80, start pulse -> cs_n low 136 cycles; done/data_wr pulse 137 cycles after start; data_out=8'h19.
REQ-032 SHALL cover: frame 16'hF380 -> data_out=8'hE7; exactly 16 rising spi_sclk edges; spi_sclk low whenever cs_n is high.
REQ-033 SHALL cover: second start pulse 50 cycles into a read -> ignored; exactly one done pulse; the next read occurs only after a new start.
REQ-034 SHALL cover: rst asserted 70 cycles into a read -> cs_n=1, sclk=0, busy=0 immediately; no data_wr; data_out=8'h00.
REQ-035 SHALL cover: TMP_CTRL_PERIODIC_EN defined, PERIOD=500, period_en=1 for 2000 cycles, no start -> 4 done pulses spaced 500 cycles apart.
REQ-036 SHALL cover: TMP_CTRL_PERIODIC_EN undefined, period_en=1 for 2000 cycles -> no cs_n activity, busy stays 0.
